// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, error codes,
// FSM states and the request classification helper.
`default_nettype none

package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } lsu_state_e;

  // Priority illegal > misaligned > out of range. funct3[1:0] gives the access size
  // for every legal encoding (0 byte, 1 half, 2 word).
  function automatic logic [1:0] classify_req(
    input logic        is_load,
    input logic        is_store,
    input logic [2:0]  funct3,
    input logic [31:0] addr,
    input logic [31:0] limit
  );
    logic illegal;
    logic misalign;
    illegal  = (is_load == is_store) ||
               (is_load  && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)) ||
               (is_store && (funct3 > 3'd2));
    misalign = ((funct3[1:0] == 2'd1) && addr[0]) ||
               ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
    if (illegal)            classify_req = ERR_ILLEGAL;
    else if (misalign)      classify_req = ERR_MISALIGN;
    else if (addr >= limit) classify_req = ERR_RANGE;
    else                    classify_req = ERR_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
// Extracts the addressed byte/half/word from a memory word and sign- or
// zero-extends it according to the load funct3.
`default_nettype none

module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = word >> {offset, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   value = {24'd0, byte_sel};
      F3_H:    value = {{16{half_sel[15]}}, half_sel};
      F3_HU:   value = {16'd0, half_sel};
      default: value = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes requests onto a synchronous word-wide data
// memory, formats load results and rejects illegal or misaligned accesses.
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        store_done,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  lsu_state_e  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        load_valid_q, load_valid_d;
  logic [31:0] load_data_q, load_data_d;
  logic        store_done_q, store_done_d;
  logic        err_valid_q, err_valid_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [1:0]  req_err;
  logic [31:0] aligned;

  load_align u_load_align (
    .word   (mem_read_data),
    .offset (off_q),
    .funct3 (f3_q),
    .value  (aligned)
  );

  assign req_err   = classify_req(req_load, req_store, req_funct3, req_addr, MEM_LIMIT);
  assign req_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d         = state_q;
    f3_d            = f3_q;
    off_d           = off_q;
    load_valid_d    = 1'b0;
    load_data_d     = load_data_q;
    store_done_d    = 1'b0;
    err_valid_d     = 1'b0;
    err_code_d      = err_code_q;
    err_addr_d      = err_addr_q;
    mem_addr        = 32'd0;
    mem_write_data  = 32'd0;
    mem_byte_enable = 4'd0;
    mem_write       = 1'b0;
    mem_read        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err != ERR_NONE) begin
            err_valid_d = 1'b1;
            err_code_d  = req_err;
            err_addr_d  = req_addr;
          end else if (req_store) begin
            mem_write    = 1'b1;
            mem_addr     = {req_addr[31:2], 2'b00};
            store_done_d = 1'b1;
            case (req_funct3)
              F3_B: begin
                mem_byte_enable = 4'b0001 << req_addr[1:0];
                mem_write_data  = {4{req_wdata[7:0]}};
              end
              F3_H: begin
                mem_byte_enable = req_addr[1] ? 4'b1100 : 4'b0011;
                mem_write_data  = {2{req_wdata[15:0]}};
              end
              default: begin
                mem_byte_enable = 4'b1111;
                mem_write_data  = req_wdata;
              end
            endcase
          end else begin
            mem_read = 1'b1;
            mem_addr = {req_addr[31:2], 2'b00};
            f3_d     = req_funct3;
            off_d    = req_addr[1:0];
            state_d  = ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        load_valid_d = 1'b1;
        load_data_d  = aligned;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      load_valid_q <= 1'b0;
      load_data_q  <= 32'd0;
      store_done_q <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= 2'd0;
      err_addr_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      store_done_q <= store_done_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign store_done = store_done_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_addr   = err_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-enabled
// synchronous memory model attached to the mem_* port.
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_load, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        load_valid, store_done, err_valid;
  logic [31:0] load_data, err_addr;
  logic [1:0]  err_code;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_write, mem_read;

  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .load_valid(load_valid), .load_data(load_data), .store_done(store_done),
    .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_byte_enable(mem_byte_enable), .mem_write(mem_write),
    .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      mem_read_data <= 32'd0;
    end else begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byte_enable[b]) mem[mem_addr[11:2]][b*8 +: 8] <= mem_write_data[b*8 +: 8];
      if (mem_read) mem_read_data <= mem[mem_addr[11:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid  = v;
    req_load   = ld;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
    drive(1'b1, 1'b0, 1'b1, f3, a, wd);
    #1;
    chk({tag, "_wr"}, {31'd0, mem_write}, 32'd1);
    chk({tag, "_be"}, {28'd0, mem_byte_enable}, {28'd0, exp_be});
    chk({tag, "_wd"}, mem_write_data, exp_wd);
    chk({tag, "_ma"}, mem_addr, {a[31:2], 2'b00});
    tick();
    idle();
    chk({tag, "_done"}, {31'd0, store_done}, 32'd1);
    tick();
    chk({tag, "_done_off"}, {31'd0, store_done}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp_data);
    drive(1'b1, 1'b1, 1'b0, f3, a, 32'd0);
    #1;
    chk({tag, "_rd"}, {31'd0, mem_read}, 32'd1);
    tick();
    idle();
    chk({tag, "_wait_rdy"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_wait_lv"}, {31'd0, load_valid}, 32'd0);
    tick();
    chk({tag, "_lv"}, {31'd0, load_valid}, 32'd1);
    chk({tag, "_data"}, load_data, exp_data);
    tick();
    chk({tag, "_lv_off"}, {31'd0, load_valid}, 32'd0);
    chk({tag, "_hold"}, load_data, exp_data);
  endtask

  task automatic do_err(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] exp_code);
    drive(1'b1, ld, st, f3, a, 32'h1234_5678);
    #1;
    chk({tag, "_nostrobe"}, {30'd0, mem_read, mem_write}, 32'd0);
    chk({tag, "_noaddr"}, mem_addr, 32'd0);
    tick();
    idle();
    chk({tag, "_ev"}, {31'd0, err_valid}, 32'd1);
    chk({tag, "_code"}, {30'd0, err_code}, {30'd0, exp_code});
    chk({tag, "_addr"}, err_addr, a);
    chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    tick();
    chk({tag, "_ev_off"}, {31'd0, err_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_pulses", {29'd0, load_valid, store_done, err_valid}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_err", {30'd0, err_code} | err_addr, 32'd0);
    chk("rst_mem", mem_addr | mem_write_data | {26'd0, mem_byte_enable, mem_write, mem_read}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    do_store("sw", 3'd2, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load("lw", 3'd2, 32'h10, 32'hDEAD_BEEF);

    do_store("sb", 3'd0, 32'h23, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    do_load("lb", 3'd0, 32'h23, 32'hFFFF_FFA5);
    do_load("lbu", 3'd4, 32'h23, 32'h0000_00A5);

    do_store("sh", 3'd1, 32'h42, 32'h0000_8001, 4'b1100, 32'h8001_8001);
    do_load("lh", 3'd1, 32'h42, 32'hFFFF_8001);
    do_load("lhu", 3'd5, 32'h42, 32'h0000_8001);
    do_store("sh_lo", 3'd1, 32'h48, 32'h0000_7FFE, 4'b0011, 32'h7FFE_7FFE);
    do_load("lh_lo", 3'd1, 32'h48, 32'h0000_7FFE);

    do_err("mis_lw", 1'b1, 1'b0, 3'd2, 32'h06, 2'b01);
    do_err("mis_sh", 1'b0, 1'b1, 3'd1, 32'h41, 2'b01);
    do_err("rng_sw", 1'b0, 1'b1, 3'd2, 32'h1000, 2'b10);
    do_err("ill_ld3", 1'b1, 1'b0, 3'd3, 32'h00, 2'b11);
    do_err("ill_both", 1'b1, 1'b1, 3'd2, 32'h1001, 2'b11);
    do_err("ill_st4", 1'b0, 1'b1, 3'd4, 32'h08, 2'b11);

    // Store held behind a load waits out LOAD_WAIT and is taken as load_valid pulses.
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h0, 32'd0);
    #1;
    chk("b2b_rd", {31'd0, mem_read}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'd2, 32'h4, 32'h1234_5678);
    #1;
    chk("b2b_wait_rdy", {31'd0, req_ready}, 32'd0);
    chk("b2b_wait_wr", {31'd0, mem_write}, 32'd0);
    tick();
    chk("b2b_lv", {31'd0, load_valid}, 32'd1);
    chk("b2b_data", load_data, 32'd0);
    chk("b2b_rdy", {31'd0, req_ready}, 32'd1);
    chk("b2b_wr", {31'd0, mem_write}, 32'd1);
    tick();
    idle();
    chk("b2b_done", {31'd0, store_done}, 32'd1);
    tick();
    do_load("b2b_lw", 3'd2, 32'h4, 32'h1234_5678);

    // Reset during LOAD_WAIT discards the in-flight read.
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
    tick();
    idle();
    chk("rstw_in_wait", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_data", load_data, 32'd0);
    chk("rstw_lv", {31'd0, load_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstw_no_lv", {31'd0, load_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
